mult_datapath: RTL and testbench
================================

// Module: mult_datapath
// PURPOSE
//   Register/arithmetic datapath for the 32-bit shift-add multiplier, slaved to the FSM control unit.
//   Consumes the FSM's B_sel/Q_sel/A_sel/N_sel commands.
//   Returns the status bits Qsub0 and N_EQ_0 that drive the FSM's transitions.
//   Holds multiplicand B, accumulator A with carry C, multiplier Q and iteration counter N.
//   The 2*WIDTH product is {A,Q}.
// PARAMETERS
//   WIDTH   32               operand width in bits
//   CNT_W   $clog2(WIDTH+1)  counter width; 6 for WIDTH=32
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        synchronous, active-high; clears every register
//   mcand_in   in   WIDTH    multiplicand, captured on B load
//   mplier_in  in   WIDTH    multiplier, captured on Q load
//   B_sel      in   2        B register command
//   Q_sel      in   2        Q register command
//   A_sel      in   2        A/C register command
//   N_sel      in   2        N counter command
//   Qsub0      out  1        Q[0]
//   N_EQ_0     out  1        1 when N==0
//   product    out  2*WIDTH  {A,Q}
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is synchronous and active-high.
//   - Reset: at the clk edge with reset=1, A, B, Q, C and N all go to 0.
//     Reset overrides all selects, so reset in the middle of a multiply aborts it.
//     After reset: Qsub0=0, N_EQ_0=1, product=0.
//   - Output timing:
//     - Every register updates on the clk edge where its select is sampled.
//     - Qsub0, N_EQ_0 and product are combinational decodes of registers; no added latency.
//     - The FSM sees the new status in the cycle after it issues a command.
//   - B_sel:
//     - 00 hold
//     - 01 B<=mcand_in
//     - 10 B<=0
//     - 11 hold (reserved)
//   - A_sel:
//     - 00 hold
//     - 01 {C,A}<=0
//     - 10 {C,A}<=A+B, computed at full WIDTH+1 bits, carry into C
//     - 11 shift right: A<={C,A[WIDTH-1:1]}, C<=0
//   - Q_sel:
//     - 00 hold
//     - 01 Q<=mplier_in
//     - 10 shift right: Q<={A[0],Q[WIDTH-1:1]}, using the pre-edge A[0]
//     - 11 Q<=0
//   - N_sel:
//     - 00 hold
//     - 01 N<=WIDTH
//     - 10 N<=N-1, saturating: N stays 0 when already 0 (no wrap)
//     - 11 N<=0
//   - Shift pairing: the FSM issues A_sel=11 and Q_sel=10 in the same cycle.
//     Together they form one 2*WIDTH+1-bit logical right shift of {C,A,Q}.
//   - Simultaneous commands: every register reads only pre-edge values, so any combination is well-defined.
//     Example: A add together with Q shift gives Q MSB = old A[0] and A = old A + B.
//   - Intended per-bit sequence: check Qsub0; if 1, add (A_sel=10); then shift (A_sel=11, Q_sel=10, N_sel=10).
//     The multiply finishes when N_EQ_0=1 after WIDTH iterations.
//   - Full-scale operands: the carry into C is never lost, so the product is exact at full width.
//     0xFFFFFFFF*0xFFFFFFFF fits in 64 bits.
// STRUCTURE
//   - Shared header mult_defs.vh, also included by the FSM, holds:
//     - localparams for every select encoding (e.g. A_SEL_HOLD, A_SEL_CLR, A_SEL_ADD, A_SEL_SHR);
//     - WIDTH;
//     - CNT_W.
//   - Sub-module mult_down_counter: N register with load / decrement-saturate / clear and the zero flag.
//   - A, B, Q, C and the adder stay inline.
// TESTING
//   1. Reset -> Qsub0=0, N_EQ_0=1, product=0.
//   2. mcand=3, mplier=5, run the full 32-iteration command sequence -> product=64'h0F, N_EQ_0=1 at the end.
//   3. mcand=mplier=32'hFFFFFFFF, full run -> product=64'hFFFFFFFE_00000001.
//      C must be observed set after the first add.
//   4. Load N=32, then 33 decrements -> N_EQ_0 rises after exactly 32 decrements and stays 1, no wrap.
//   5. Assert reset=1 at iteration 10 with all selects active -> next cycle all registers are 0.
//      Selects issued during reset are ignored.
//   6. A_sel=10 and Q_sel=10 in the same cycle with A=1, B=2, Q=4 -> A=3, Q=32'h80000002.

Source files
------------

// File: rtl/mult_datapath_pkg.sv
// Shared definitions for the shift-add multiplier: operand width, counter width
// and the command encodings that the FSM drives into the datapath.
package mult_datapath_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH + 1);

    typedef enum logic [1:0] {
        B_SEL_HOLD = 2'b00,
        B_SEL_LOAD = 2'b01,
        B_SEL_CLR  = 2'b10,
        B_SEL_RSVD = 2'b11
    } b_sel_t;

    typedef enum logic [1:0] {
        A_SEL_HOLD = 2'b00,
        A_SEL_CLR  = 2'b01,
        A_SEL_ADD  = 2'b10,
        A_SEL_SHR  = 2'b11
    } a_sel_t;

    typedef enum logic [1:0] {
        Q_SEL_HOLD = 2'b00,
        Q_SEL_LOAD = 2'b01,
        Q_SEL_SHR  = 2'b10,
        Q_SEL_CLR  = 2'b11
    } q_sel_t;

    typedef enum logic [1:0] {
        N_SEL_HOLD = 2'b00,
        N_SEL_LOAD = 2'b01,
        N_SEL_DEC  = 2'b10,
        N_SEL_CLR  = 2'b11
    } n_sel_t;

endpackage

// File: rtl/mult_datapath_if.sv
// Command/status/operand bundle between the multiplier FSM (master) and the
// datapath (slave).
interface mult_datapath_if
    import mult_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
);

    logic [WIDTH-1:0]   mcand_in;
    logic [WIDTH-1:0]   mplier_in;
    b_sel_t             B_sel;
    q_sel_t             Q_sel;
    a_sel_t             A_sel;
    n_sel_t             N_sel;
    logic               Qsub0;
    logic               N_EQ_0;
    logic [2*WIDTH-1:0] product;

    modport master (
        output mcand_in, mplier_in, B_sel, Q_sel, A_sel, N_sel,
        input  Qsub0, N_EQ_0, product
    );

    modport slave (
        input  mcand_in, mplier_in, B_sel, Q_sel, A_sel, N_sel,
        output Qsub0, N_EQ_0, product
    );

endinterface

// File: rtl/mult_datapath_counter.sv
// Iteration counter N: load WIDTH, saturating decrement, clear, and a zero flag.
module mult_down_counter
    import mult_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic   clk,
    input  logic   reset,
    input  n_sel_t n_sel,
    output logic   n_eq_0
);

    logic [CNT_W-1:0] n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q <= '0;
        end else begin
            case (n_sel)
                N_SEL_HOLD: n_q <= n_q;
                N_SEL_LOAD: n_q <= CNT_W'(WIDTH);
                // Saturate at zero so extra decrements never wrap to all-ones.
                N_SEL_DEC:  if (n_q != '0) n_q <= n_q - 1'b1;
                N_SEL_CLR:  n_q <= '0;
                default:    n_q <= n_q;
            endcase
        end
    end

    assign n_eq_0 = (n_q == '0);

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: B, A with carry C, Q and the N counter,
// driven by FSM select commands; the product is {A,Q}.
module mult_datapath
    import mult_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    mult_datapath_if.slave bus
);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic             c_q;
    logic [WIDTH:0]   sum;

    // Full WIDTH+1 add so the carry out of A is kept in C.
    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            b_q <= '0;
        end else begin
            case (bus.B_sel)
                B_SEL_HOLD: b_q <= b_q;
                B_SEL_LOAD: b_q <= bus.mcand_in;
                B_SEL_CLR:  b_q <= '0;
                B_SEL_RSVD: b_q <= b_q;
                default:    b_q <= b_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            c_q <= 1'b0;
        end else begin
            case (bus.A_sel)
                A_SEL_HOLD: begin
                    a_q <= a_q;
                    c_q <= c_q;
                end
                A_SEL_CLR: begin
                    a_q <= '0;
                    c_q <= 1'b0;
                end
                A_SEL_ADD: begin
                    a_q <= sum[WIDTH-1:0];
                    c_q <= sum[WIDTH];
                end
                A_SEL_SHR: begin
                    a_q <= {c_q, a_q[WIDTH-1:1]};
                    c_q <= 1'b0;
                end
                default: begin
                    a_q <= a_q;
                    c_q <= c_q;
                end
            endcase
        end
    end

    // Shift takes the pre-edge A[0], so pairing with an A add or shift stays
    // a single right shift of {C,A,Q}.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            case (bus.Q_sel)
                Q_SEL_HOLD: q_q <= q_q;
                Q_SEL_LOAD: q_q <= bus.mplier_in;
                Q_SEL_SHR:  q_q <= {a_q[0], q_q[WIDTH-1:1]};
                Q_SEL_CLR:  q_q <= '0;
                default:    q_q <= q_q;
            endcase
        end
    end

    mult_down_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .n_sel  (bus.N_sel),
        .n_eq_0 (bus.N_EQ_0)
    );

    assign bus.Qsub0   = q_q[0];
    assign bus.product = {a_q, q_q};

endmodule

// File: tb/tb_mult_datapath.sv
// Directed and random checks of mult_datapath against a 65-bit {C,A,Q} model
// and plain integer multiplication.
module tb_mult_datapath;
    import mult_datapath_pkg::*;

    localparam int unsigned W = MULT_WIDTH;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mult_datapath_if #(.WIDTH(W)) bus ();

    mult_datapath #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input b_sel_t b, input q_sel_t q, input a_sel_t a, input n_sel_t n);
        bus.B_sel = b;
        bus.Q_sel = q;
        bus.A_sel = a;
        bus.N_sel = n;
        @(posedge clk);
        #1;
        bus.B_sel = B_SEL_HOLD;
        bus.Q_sel = Q_SEL_HOLD;
        bus.A_sel = A_SEL_HOLD;
        bus.N_sel = N_SEL_HOLD;
    endtask

    // Runs `iters` iterations of the intended check/add/shift sequence; full runs
    // are compared with the integer product.
    task automatic run_multiply(input logic [31:0] mc, input logic [31:0] mp,
                                input int iters, output logic saw_carry);
        logic [64:0] acc;
        logic [32:0] s;
        int          n_left;
        saw_carry     = 1'b0;
        bus.mcand_in  = mc;
        bus.mplier_in = mp;
        cmd(B_SEL_LOAD, Q_SEL_LOAD, A_SEL_CLR, N_SEL_LOAD);
        acc    = {33'b0, mp};
        n_left = 32;
        check("start_n", 64'(bus.N_EQ_0), 64'(0));
        for (int i = 0; i < iters; i++) begin
            check("qsub0", 64'(bus.Qsub0), 64'(acc[0]));
            if (acc[0]) begin
                cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_ADD, N_SEL_HOLD);
                s   = 33'(acc[63:32]) + 33'(mc);
                acc = {s, acc[31:0]};
                check("carry", 64'(dut.c_q), 64'(s[32]));
                if (s[32]) saw_carry = 1'b1;
            end
            cmd(B_SEL_HOLD, Q_SEL_SHR, A_SEL_SHR, N_SEL_DEC);
            acc    = acc >> 1;
            n_left = n_left - 1;
        end
        check("n_eq_0", 64'(bus.N_EQ_0), 64'(n_left == 0));
        check("partial", bus.product, acc[63:0]);
        if (iters == 32)
            check("product", bus.product, 64'(mc) * 64'(mp));
    endtask

    initial begin
        logic        carry_seen;
        logic [31:0] ra, rb;
        int          n_model;

        n_checks = 0;
        n_fail   = 0;
        bus.mcand_in  = '0;
        bus.mplier_in = '0;
        bus.B_sel = B_SEL_HOLD;
        bus.Q_sel = Q_SEL_HOLD;
        bus.A_sel = A_SEL_HOLD;
        bus.N_sel = N_SEL_HOLD;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_qsub0", 64'(bus.Qsub0), 64'(0));
        check("rst_neq0", 64'(bus.N_EQ_0), 64'(1));
        check("rst_product", bus.product, 64'h0);

        run_multiply(32'd3, 32'd5, 32, carry_seen);
        check("p3x5", bus.product, 64'h0F);

        run_multiply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, carry_seen);
        check("pmax", bus.product, 64'hFFFF_FFFE_0000_0001);
        check("pmax_carry_seen", 64'(carry_seen), 64'(1));

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom;
            run_multiply(ra, rb, 32, carry_seen);
        end

        // Counter: 33 saturating decrements after a load.
        cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_HOLD, N_SEL_LOAD);
        n_model = 32;
        check("cnt_load", 64'(bus.N_EQ_0), 64'(0));
        for (int k = 0; k < 33; k++) begin
            cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_HOLD, N_SEL_DEC);
            n_model = (n_model > 0) ? n_model - 1 : 0;
            check("cnt_dec", 64'(bus.N_EQ_0), 64'(n_model == 0));
        end
        cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_HOLD, N_SEL_DEC);
        check("cnt_sat", 64'(bus.N_EQ_0), 64'(1));

        // Reset in mid multiply with every select active.
        run_multiply(32'hDEAD_BEEF, 32'hFFFF_FFFF, 10, carry_seen);
        bus.mcand_in  = 32'h1234_5678;
        bus.mplier_in = 32'h8765_4321;
        reset = 1'b1;
        cmd(B_SEL_LOAD, Q_SEL_LOAD, A_SEL_ADD, N_SEL_LOAD);
        reset = 1'b0;
        check("mrst_product", bus.product, 64'h0);
        check("mrst_neq0", 64'(bus.N_EQ_0), 64'(1));
        check("mrst_qsub0", 64'(bus.Qsub0), 64'(0));
        check("mrst_c", 64'(dut.c_q), 64'(0));
        cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_ADD, N_SEL_HOLD);
        check("mrst_b_zero", bus.product, 64'h0);

        // Simultaneous add and Q shift: Q takes the pre-edge A[0].
        bus.mcand_in  = 32'd1;
        bus.mplier_in = 32'd4;
        cmd(B_SEL_LOAD, Q_SEL_LOAD, A_SEL_CLR, N_SEL_HOLD);
        cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_ADD, N_SEL_HOLD);
        bus.mcand_in = 32'd2;
        cmd(B_SEL_LOAD, Q_SEL_HOLD, A_SEL_HOLD, N_SEL_HOLD);
        check("sim_pre", bus.product, 64'h0000_0001_0000_0004);
        cmd(B_SEL_HOLD, Q_SEL_SHR, A_SEL_ADD, N_SEL_HOLD);
        check("sim_add_shift", bus.product, 64'h0000_0003_8000_0002);

        // Clear commands for B, Q and N.
        cmd(B_SEL_CLR, Q_SEL_CLR, A_SEL_CLR, N_SEL_LOAD);
        cmd(B_SEL_HOLD, Q_SEL_HOLD, A_SEL_ADD, N_SEL_CLR);
        check("clr_product", bus.product, 64'h0);
        check("clr_n", 64'(bus.N_EQ_0), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
